// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 4-stage pipeline (fetch, rf_read, execute, writeback).
// Latency: 0 cycles; enables, bubble and flush are combinational from state and inputs.
// Backpressure: memory waitrequest freezes every stage; load-use and taken branches stall or squash.
module pipe_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      i_ir_rf,
   input  logic [15:0]      i_ir_ex,
   input  logic             i_ir_ex_valid,
   input  logic             i_branch_taken,
   input  logic             i_mem_waitrequest,
   output logic             o_pc_en,
   output logic             o_rf_en,
   output logic             o_ex_en,
   output logic             o_wb_en,
   output logic             o_ex_bubble,
   output logic             o_flush,
   output logic [CNT_W-1:0] o_stall_count,
   output logic [1:0]       o_state
);

   // Opcode encodings shared with the instruction set definition
   localparam logic [3:0] OP_LD   = 4'd0;
   localparam logic [3:0] OP_ST   = 4'd1;
   localparam logic [3:0] OP_MV   = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_CMP  = 4'd5;
   localparam logic [3:0] OP_J    = 4'd8;
   localparam logic [3:0] OP_JN   = 4'd9;
   localparam logic [3:0] OP_JZ   = 4'd10;
   localparam logic [3:0] OP_CALL = 4'd11;

   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_LDSTALL = 2'd1,
      S_FLUSH   = 2'd2,
      S_FREEZE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   state_t           saved_q, saved_d;
   state_t           eff_state;
   logic [1:0]       fcnt_q, fcnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic [3:0] rf_op, ex_op;
   logic       rf_imm;
   logic [2:0] rf_rx, rf_ry, ex_rx;
   logic       reads_rx, reads_ry, load_use;
   logic       unused_ir;

   assign rf_op  = i_ir_rf[3:0];
   assign rf_imm = i_ir_rf[4];
   assign rf_rx  = i_ir_rf[7:5];
   assign rf_ry  = i_ir_rf[10:8];
   assign ex_op  = i_ir_ex[3:0];
   assign ex_rx  = i_ir_ex[7:5];
   assign unused_ir = ^{i_ir_rf[15:11], i_ir_ex[15:8], i_ir_ex[4]};

   // Register-read decode of the rf_read instruction and load-use detection
   always_comb begin
      reads_rx = 1'b0;
      reads_ry = 1'b0;
      if (!rf_imm) begin
         reads_rx = (rf_op == OP_ADD) || (rf_op == OP_SUB) || (rf_op == OP_CMP) ||
                    (rf_op == OP_ST)  || (rf_op == OP_J)   || (rf_op == OP_JN)  ||
                    (rf_op == OP_JZ)  || (rf_op == OP_CALL);
         reads_ry = (rf_op == OP_MV) || (rf_op == OP_ADD) || (rf_op == OP_SUB) ||
                    (rf_op == OP_CMP);
      end else begin
         reads_rx = (rf_op == OP_ADD) || (rf_op == OP_SUB) || (rf_op == OP_CMP);
      end
      if ((rf_op == OP_LD) || (rf_op == OP_ST)) begin
         reads_ry = 1'b1;
      end
      load_use = i_ir_ex_valid && (ex_op == OP_LD) &&
                 ((reads_rx && (rf_rx == ex_rx)) || (reads_ry && (rf_ry == ex_rx)));
   end

   // Next-state and output decode; a released freeze behaves as the state it interrupted
   always_comb begin
      eff_state   = (state_q == S_FREEZE) ? saved_q : state_q;
      state_d     = eff_state;
      saved_d     = saved_q;
      fcnt_d      = fcnt_q;
      o_pc_en     = 1'b1;
      o_rf_en     = 1'b1;
      o_ex_en     = 1'b1;
      o_wb_en     = 1'b1;
      o_ex_bubble = 1'b0;
      o_flush     = 1'b0;
      if (!reset) begin
         state_d = S_RUN;
         o_pc_en = 1'b0;
         o_rf_en = 1'b0;
         o_ex_en = 1'b0;
         o_wb_en = 1'b0;
      end else if (i_mem_waitrequest) begin
         state_d = S_FREEZE;
         if (state_q != S_FREEZE) begin
            saved_d = state_q;
         end
         o_pc_en = 1'b0;
         o_rf_en = 1'b0;
         o_ex_en = 1'b0;
         o_wb_en = 1'b0;
      end else begin
         case (eff_state)
            S_RUN, S_LDSTALL: begin
               if (i_branch_taken) begin
                  o_flush     = 1'b1;
                  o_ex_bubble = 1'b1;
                  fcnt_d      = FLUSH_LOAD;
                  state_d     = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
               end else if ((eff_state == S_RUN) && load_use) begin
                  o_pc_en     = 1'b0;
                  o_rf_en     = 1'b0;
                  o_ex_bubble = 1'b1;
                  state_d     = S_LDSTALL;
               end else begin
                  state_d = S_RUN;
               end
            end
            S_FLUSH: begin
               o_flush     = 1'b1;
               o_ex_bubble = 1'b1;
               if (fcnt_q <= 2'd1) begin
                  fcnt_d  = 2'd0;
                  state_d = S_RUN;
               end else begin
                  fcnt_d = fcnt_q - 2'd1;
               end
            end
            default: state_d = S_RUN;
         endcase
      end
   end

   // Saturating count of cycles in which fetch is held
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!o_pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // State, flush counter, saved state and stall counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_RUN;
         saved_q     <= S_RUN;
         fcnt_q      <= 2'd0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         saved_q     <= saved_d;
         fcnt_q      <= fcnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_stall_count = stall_cnt_q;
   assign o_state       = state_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 4-stage pipeline (fetch, rf_read, execute, writeback).
- Decides each cycle which pipeline registers load, which stage receives a bubble, and when younger instructions are squashed.
- Inputs are the per-stage instruction registers, the taken-branch flag from execute, and the data-memory waitrequest.
- Complements writeback-to-earlier-stage forwarding by covering the hazards forwarding cannot resolve: load-use, taken control transfer, and memory wait.

Parameters:
FLUSH_CYCLES, 2, number of cycles o_flush is held after a taken branch; range 1..3.
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
i_ir_rf  input  16  instruction in rf_read stage
i_ir_ex  input  16  instruction in execute stage
i_ir_ex_valid  input  1  execute-stage instruction is real (not a bubble)
i_branch_taken  input  1  execute-stage J/JN/JZ/CALL resolved taken this cycle
i_mem_waitrequest  input  1  data memory cannot complete the access this cycle
o_pc_en  output  1  PC/fetch register load enable
o_rf_en  output  1  rf_read pipeline register load enable
o_ex_en  output  1  execute pipeline register load enable
o_wb_en  output  1  writeback pipeline register load enable
o_ex_bubble  output  1  load NOP into execute register instead of rf_read contents
o_flush  output  1  squash fetch and rf_read contents (load NOP)
o_stall_count  output  CNT_W  saturating count of cycles with o_pc_en low
o_state  output  2  current FSM state, for debug

Behaviour:
Decode (op.vh encodings: op = IR[3:0], imm = IR[4], Rx = IR[7:5], Ry = IR[10:8]):
- rf instruction reads Rx for ADD_X, SUB_X, CMP_X, ST, J_X, JN_X, JZ_X, CALL_X when imm = 0.
- rf instruction reads Ry for MV_X, ADD_X, SUB_X, CMP_X when imm = 0, and always for LD and ST.
- rf instruction reads Rx for ADD_X, SUB_X, CMP_X when imm = 1.
- load_use = i_ir_ex_valid AND ex op == OP_LD AND ex Rx equals any register read by the rf instruction.

FSM states: S_RUN = 0, S_LDSTALL = 1, S_FLUSH = 2, S_FREEZE = 3.

Each cycle is evaluated in priority order:
- i_mem_waitrequest high:
  - Next state S_FREEZE.
  - All four enables are 0; o_ex_bubble = 0; o_flush = 0.
  - Flush counter and pending load-stall are held.
- Else i_branch_taken (evaluated only in S_RUN or S_LDSTALL):
  - o_flush = 1 this cycle; all enables = 1; o_ex_bubble = 1.
  - Load flush counter with FLUSH_CYCLES-1; next state S_FLUSH if FLUSH_CYCLES > 1, else S_RUN.
  - The branch overrides load_use.
- Else load_use in S_RUN:
  - o_pc_en = 0; o_rf_en = 0; o_ex_en = 1 with o_ex_bubble = 1; o_wb_en = 1.
  - Next state S_LDSTALL.
- S_LDSTALL:
  - Exactly one stall cycle has completed; all enables = 1, no bubble.
  - Next state S_RUN; load_use is re-evaluated in S_RUN only.
- S_FLUSH:
  - o_flush = 1; all enables = 1; o_ex_bubble = 1; decrement counter.
  - Return to S_RUN when the counter reaches 0.
  - i_branch_taken is ignored here (execute holds a bubble).
- S_FREEZE:
  - Stays while waitrequest is high.
  - On release, returns to the saved prior state (S_RUN, S_LDSTALL or S_FLUSH) with the counter intact.
- S_RUN with no hazard: all enables = 1; o_ex_bubble = 0; o_flush = 0.

Timing and counter:
- All outputs are combinational from state plus inputs; state updates on the clock edge.
- Response is 0 cycles from the hazard appearing to the enables dropping.
- o_stall_count increments on every cycle with o_pc_en = 0 and saturates at all-ones (no wrap).

Reset (asserted low, asynchronous):
- State S_RUN, flush counter 0, saved state S_RUN, o_stall_count 0.
- Outputs during reset: all enables 0, o_ex_bubble 0, o_flush 0.
- Reset mid-stall or mid-flush abandons the sequence; the first cycle after release is S_RUN.

Test Plan:
1. LD r2 in ex (valid), ADD r3,r2 in rf -> cycle 0: pc_en = 0, rf_en = 0, ex_bubble = 1; state 1; next cycle all enables 1; stall_count = 1.
2. LD r2 in ex, ADD r3,#5 with Rx = r3 in rf (no read of r2) -> no stall, all enables 1; repeat with i_ir_ex_valid = 0 and a matching register -> no stall.
3. i_branch_taken pulse, FLUSH_CYCLES = 2 -> o_flush high for exactly 2 cycles, state 2 then 0; stall_count unchanged.
4. waitrequest high for 3 cycles during S_FLUSH with counter 1 -> enables 0 for 3 cycles, state 3, then one more flush cycle, then S_RUN; stall_count += 3.
5. Branch taken and load_use in the same cycle -> flush wins, no S_LDSTALL entry.
6. Force CNT_W = 4 and hold waitrequest for 20 cycles -> o_stall_count saturates at 15; assert reset mid-freeze -> state 0, count 0 immediately.
